// File: rtl/sevenseg_capture.sv
// Receive side of the multiplexed active-low 7-segment bus: synchronizes seg/an,
// waits for each digit to settle, decodes it back to a status code and assembles frames.
module sevenseg_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 33554432
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] codes,
    output logic [3:0]  status,
    output logic        frame_valid,
    output logic        bad_pattern,
    output logic        bad_an,
    output logic        stale
);

    localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [STALE_W-1:0] stale_cnt;
    logic [3:0]         mask;
    logic [3:0]         mask_n;
    logic [15:0]        codes_n;

    logic [6:0] seg_s1;
    logic [6:0] seg_s2;
    logic [6:0] seg_prev;
    logic [3:0] an_s1;
    logic [3:0] an_s2;
    logic [3:0] an_prev;

    logic       an_valid;
    logic       changed;
    logic       capture;
    logic [3:0] code;
    logic       code_bad;
    logic       frame_done;

    // Returns {unknown_flag, code}; unknown patterns decode to F.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1000111: r = {1'b0, 4'h8};
            7'b1000110: r = {1'b0, 4'h4};
            7'b0101111: r = {1'b0, 4'h2};
            7'b0100011: r = {1'b0, 4'h1};
            default:    r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    // Two-flop synchronizers plus a one-cycle history for the stability check.
    // These carry data only, so they are left out of reset.
    always_ff @(posedge clk) begin
        seg_s1   <= seg;
        seg_s2   <= seg_s1;
        seg_prev <= seg_s2;
        an_s1    <= an;
        an_s2    <= an_s1;
        an_prev  <= an_s2;
    end

    always_comb begin
        an_valid = 1'b0;
        case (an_s2)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_valid = 1'b1;
            default:                            an_valid = 1'b0;
        endcase
    end

    assign changed = (seg_s2 != seg_prev) || (an_s2 != an_prev);
    assign {code_bad, code} = decode_seg(seg_s2);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (!an_valid) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SETTLE;
                    cnt_n   = CNT_W'(1);
                end
                SETTLE: begin
                    if (changed) begin
                        cnt_n = CNT_W'(1);
                    end else if (cnt == CNT_W'(SETTLE_CYCLES)) begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state_n = SETTLE;
                        cnt_n   = CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // The anode is active low and one-hot when valid, so ~an_s2 selects the nibble.
    always_comb begin
        codes_n = codes;
        mask_n  = mask;
        for (int i = 0; i < 4; i++) begin
            if (!an_s2[i]) begin
                codes_n[i*4 +: 4] = code;
                mask_n[i]         = 1'b1;
            end
        end
    end

    assign frame_done = (mask_n == 4'b1111);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            stale_cnt   <= '0;
            mask        <= '0;
            codes       <= '0;
            frame_valid <= 1'b0;
            bad_pattern <= 1'b0;
            bad_an      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            frame_valid <= 1'b0;
            bad_pattern <= 1'b0;
            if (!an_valid) begin
                bad_an <= 1'b1;
            end
            if (capture) begin
                codes       <= codes_n;
                bad_pattern <= code_bad;
                frame_valid <= frame_done;
                mask        <= frame_done ? 4'b0000 : mask_n;
                stale_cnt   <= '0;
            end else if (stale_cnt != STALE_W'(TIMEOUT_CYCLES)) begin
                stale_cnt <= stale_cnt + STALE_W'(1);
            end
        end
    end

    assign status = codes[3:0];
    assign stale  = (stale_cnt == STALE_W'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomized self-checking bench for sevenseg_capture against a run-length reference model.
module tb_sevenseg_capture;

    localparam int N = 16;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] codes;
    logic [3:0]  status;
    logic        frame_valid;
    logic        bad_pattern;
    logic        bad_an;
    logic        stale;

    sevenseg_capture #(
        .SETTLE_CYCLES (N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .codes      (codes),
        .status     (status),
        .frame_valid(frame_valid),
        .bad_pattern(bad_pattern),
        .bad_an     (bad_an),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] P_ZERO = 7'b1000000;
    localparam logic [6:0] P_L    = 7'b1000111;
    localparam logic [6:0] P_C    = 7'b1000110;
    localparam logic [6:0] P_R    = 7'b0101111;
    localparam logic [6:0] P_O    = 7'b0100011;

    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] pat_tab [5] = '{P_ZERO, P_L, P_C, P_R, P_O};

    int n_checks = 0;
    int n_pass   = 0;
    int fv_count = 0;
    int bp_count = 0;

    // Reference model state: pins seen two edges ago are what the logic acts on.
    logic [6:0]  d1_seg, d2_seg;
    logic [3:0]  d1_an, d2_an;
    logic [10:0] m_last;
    int          m_run;
    int          m_stale;
    logic [15:0] m_codes;
    logic [3:0]  m_mask;
    logic        m_fv, m_bp, m_bad_an;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] ref_code(input logic [6:0] s);
        case (s)
            P_ZERO:  return 4'h0;
            P_L:     return 4'h8;
            P_C:     return 4'h4;
            P_R:     return 4'h2;
            P_O:     return 4'h1;
            default: return 4'hF;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [6:0] s, input logic [3:0] a);
        logic [6:0] xs;
        logic [3:0] xa;
        logic [3:0] c;
        xs = d2_seg;
        xa = d2_an;
        d2_seg = d1_seg; d1_seg = s;
        d2_an  = d1_an;  d1_an  = a;
        m_fv = 1'b0;
        m_bp = 1'b0;
        if (!r) begin
            m_run = 0; m_stale = 0; m_codes = '0; m_mask = '0; m_bad_an = 1'b0;
        end else begin
            if ($countones(~xa) != 1) begin
                m_bad_an = 1'b1;
                m_run    = 0;
            end else if (m_run > 0 && {xa, xs} == m_last) begin
                m_run++;
            end else begin
                m_run = 1;
            end
            m_last = {xa, xs};
            // A digit is accepted after N+1 identical consecutive observations.
            if (m_run == N + 1) begin
                c = ref_code(xs);
                if (c == 4'hF) m_bp = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (!xa[i]) begin
                        m_codes[i*4 +: 4] = c;
                        m_mask[i] = 1'b1;
                    end
                end
                if (m_mask == 4'hF) begin
                    m_fv   = 1'b1;
                    m_mask = '0;
                end
                m_stale = 0;
            end else if (m_stale < T) begin
                m_stale++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [6:0] s, input logic [3:0] a);
        @(negedge clk);
        rst_n = r;
        seg   = s;
        an    = a;
        @(posedge clk);
        #1;
        model_edge(r, s, a);
        if (frame_valid) fv_count++;
        if (bad_pattern) bp_count++;
        check_eq("codes",       32'(codes),       32'(m_codes));
        check_eq("status",      32'(status),      32'(m_codes[3:0]));
        check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
        check_eq("bad_pattern", 32'(bad_pattern), 32'(m_bp));
        check_eq("bad_an",      32'(bad_an),      32'(m_bad_an));
        check_eq("stale",       32'(stale),       32'(m_stale == T));
    endtask

    initial begin
        logic [15:0] saved;
        logic [6:0]  rs;
        logic [3:0]  ra;
        logic        rr;
        int          hold;
        int          cyc;

        rst_n = 1'b0; seg = 7'h7F; an = 4'b1110;
        d1_seg = 7'h7F; d2_seg = 7'h7F; d1_an = 4'b1110; d2_an = 4'b1110;
        m_last = '0; m_run = 0; m_stale = 0; m_codes = '0; m_mask = '0;
        m_fv = 1'b0; m_bp = 1'b0; m_bad_an = 1'b0;

        // Reset with an arbitrary (valid-anode) bus
        repeat (3) step(1'b0, 7'($urandom()), an_tab[$urandom_range(0, 3)]);
        check_eq("rst_codes", 32'(codes), 32'h0);
        check_eq("rst_flags", 32'({frame_valid, bad_pattern, bad_an, stale}), 32'h0);

        // Single L digit
        bp_count = 0; fv_count = 0;
        repeat (20) step(1'b1, P_L, 4'b1110);
        check_eq("L_status", 32'(status), 32'h8);
        check_eq("L_no_bad", 32'(bp_count), 32'h0);
        check_eq("L_no_frame", 32'(fv_count), 32'h0);

        // Full frame rotation from a fresh reset
        repeat (3) step(1'b0, P_L, 4'b1110);
        fv_count = 0;
        for (int d = 0; d < 4; d++)
            repeat (40) step(1'b1, (d == 0) ? P_L : P_ZERO, an_tab[d]);
        check_eq("rot_codes", 32'(codes), 32'h0008);
        check_eq("rot_frames", 32'(fv_count), 32'h1);

        // One-cycle glitch restarts the settle window
        bp_count = 0;
        for (int i = 0; i < 40; i++)
            step(1'b1, (i == 10) ? 7'h7F : P_C, 4'b1110);
        check_eq("glitch_status", 32'(status), 32'h4);
        check_eq("glitch_no_bad", 32'(bp_count), 32'h0);

        // Unknown pattern, then an illegal anode
        bp_count = 0;
        repeat (25) step(1'b1, 7'h7F, 4'b1101);
        check_eq("bad_nibble", 32'(codes[7:4]), 32'hF);
        check_eq("bad_pulses", 32'(bp_count), 32'h1);
        saved = codes;
        repeat (5) step(1'b1, 7'h7F, 4'b1100);
        check_eq("bad_an_set", 32'(bad_an), 32'h1);
        check_eq("bad_an_hold", 32'(codes), 32'(saved));

        // Staleness after a frozen bus, cleared by the next capture
        repeat (3) step(1'b0, P_R, 4'b1011);
        repeat (90) step(1'b1, P_R, 4'b1011);
        check_eq("stale_set", 32'(stale), 32'h1);
        repeat (20) step(1'b1, P_O, 4'b0111);
        check_eq("stale_clr", 32'(stale), 32'h0);
        check_eq("stale_code", 32'(codes[15:12]), 32'h1);

        // Randomized traffic with occasional resets, illegal anodes and junk patterns
        cyc = 0;
        while (cyc < 3000) begin
            rr   = ($urandom_range(0, 59) != 0);
            hold = rr ? $urandom_range(1, 40) : $urandom_range(1, 3);
            ra   = ($urandom_range(0, 9) != 0) ? an_tab[$urandom_range(0, 3)] : 4'($urandom());
            rs   = ($urandom_range(0, 4) != 0) ? pat_tab[$urandom_range(0, 4)] : 7'($urandom());
            repeat (hold) step(rr, rs, ra);
            cyc += hold;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
